fsm_pin_output_mapper: RTL

// - Per-state-machine pin output stage: holds one FSM's 32-bit pin-value and pin-direction registers.
// - Applies OUT / SET / MOV / side-set writes through base+count pin windows that wrap modulo 32.
// - Feeds fsm_output[n] / fsm_drive[n] of the output arbitrator; one instance per FSM (4 total).

---
 rtl/fsm_pin_output_mapper_pkg.sv | 28 ++
 rtl/fsm_pin_output_mapper_window.sv | 23 ++
 rtl/fsm_pin_output_mapper.sv | 101 ++++++++++
 3 files changed

// File: rtl/fsm_pin_output_mapper_pkg.sv
// Shared encodings, sizes and window helpers for the per-FSM pin output stage.
// Pure definitions: no latency, no flow control.
package fsm_pin_output_mapper_pkg;

  localparam int NUM_PINS = 32;
  localparam int SET_MAX  = 5;

  localparam logic [5:0] OUT_CNT_MAX = 6'(NUM_PINS);
  localparam logic [5:0] SET_CNT_MAX = 6'(SET_MAX);

  localparam logic [1:0] SRC_OUT = 2'd0;
  localparam logic [1:0] SRC_SET = 2'd1;
  localparam logic [1:0] SRC_MOV = 2'd2;

  localparam logic TGT_PINS = 1'b0;
  localparam logic TGT_DIRS = 1'b1;

  function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] s);
    logic [63:0] d;
    d = {v, v} << s;
    return d[63:32];
  endfunction

  function automatic logic [5:0] clamp_count(input logic [5:0] c, input logic [5:0] max_c);
    return (c > max_c) ? max_c : c;
  endfunction

endpackage

// File: rtl/fsm_pin_output_mapper_window.sv
// Maps a base+count pin window onto the 32-pin ring: mask plus data rotated into place.
// Combinational, no flow control.
module pin_window_rotate
  import fsm_pin_output_mapper_pkg::*;
(
  input  logic [4:0]  base,
  input  logic [5:0]  count,
  input  logic [31:0] data,
  output logic [31:0] mask,
  output logic [31:0] rot_data
);

  logic [31:0] low_mask;

  always_comb begin
    if (count >= 6'd32) low_mask = '1;
    else                low_mask = (32'd1 << count) - 32'd1;
    // Rotation implements the mod-32 wrap; a full-width window maps every pin exactly once.
    mask     = rotl32(low_mask, base);
    rot_data = rotl32(data & low_mask, base);
  end

endmodule

// File: rtl/fsm_pin_output_mapper.sv
// Per-FSM pin value/direction registers updated by OUT/SET/MOV and side-set windows.
// Writes visible one cycle after the strobe edge; no backpressure, every strobe applies once.
module fsm_pin_output_mapper
  import fsm_pin_output_mapper_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [4:0]  out_base,
  input  logic [5:0]  out_count,
  input  logic [4:0]  set_base,
  input  logic [2:0]  set_count,
  input  logic [4:0]  ss_base,
  input  logic [2:0]  ss_count,
  input  logic        ss_pindirs,
  input  logic        wr_en,
  input  logic [1:0]  wr_src,
  input  logic        wr_target,
  input  logic [31:0] wr_data,
  input  logic        ss_valid,
  input  logic [4:0]  ss_data,
  output logic [31:0] fsm_output,
  output logic [31:0] fsm_drive
);

  logic [31:0] out_mask, out_rot;
  logic [31:0] set_mask, set_rot;
  logic [31:0] ss_mask,  ss_rot;
  logic [31:0] ins_mask, ins_rot;
  logic        ins_vld;
  logic [31:0] nxt_output, nxt_drive;

  pin_window_rotate u_out_win (
    .base     (out_base),
    .count    (clamp_count(out_count, OUT_CNT_MAX)),
    .data     (wr_data),
    .mask     (out_mask),
    .rot_data (out_rot)
  );

  pin_window_rotate u_set_win (
    .base     (set_base),
    .count    (clamp_count({3'b000, set_count}, SET_CNT_MAX)),
    .data     (wr_data),
    .mask     (set_mask),
    .rot_data (set_rot)
  );

  pin_window_rotate u_ss_win (
    .base     (ss_base),
    .count    (clamp_count({3'b000, ss_count}, SET_CNT_MAX)),
    .data     ({27'd0, ss_data}),
    .mask     (ss_mask),
    .rot_data (ss_rot)
  );

  always_comb begin
    ins_vld    = 1'b0;
    ins_mask   = '0;
    ins_rot    = '0;
    nxt_output = fsm_output;
    nxt_drive  = fsm_drive;

    case (wr_src)
      SRC_OUT, SRC_MOV: begin
        ins_vld  = wr_en;
        ins_mask = out_mask;
        ins_rot  = out_rot;
      end
      SRC_SET: begin
        ins_vld  = wr_en;
        ins_mask = set_mask;
        ins_rot  = set_rot;
      end
      default: ins_vld = 1'b0;
    endcase

    if (enable) begin
      // Instruction first, side-set second, so side-set owns any shared pin.
      if (ins_vld) begin
        if (wr_target == TGT_DIRS) nxt_drive  = (nxt_drive  & ~ins_mask) | (ins_rot & ins_mask);
        else                       nxt_output = (nxt_output & ~ins_mask) | (ins_rot & ins_mask);
      end
      if (ss_valid) begin
        if (ss_pindirs) nxt_drive  = (nxt_drive  & ~ss_mask) | (ss_rot & ss_mask);
        else            nxt_output = (nxt_output & ~ss_mask) | (ss_rot & ss_mask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_output <= '0;
      fsm_drive  <= '0;
    end else begin
      fsm_output <= nxt_output;
      fsm_drive  <= nxt_drive;
    end
  end

endmodule
